// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier control unit.
package mult_pkg;

  localparam int unsigned MULT_N     = 4;
  localparam int unsigned MULT_ACC_W = 2 * MULT_N + 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StTest,
    StShift,
    StDone
  } mult_state_e;

  // Never returns 0 so a counter for N=1 still has a real bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((32'd1 << width) < value) width++;
    return width;
  endfunction

endpackage

// File: rtl/mult_step_cnt.sv
// Modulo-N step counter; counts completed shifts and flags the final one.
module mult_step_cnt
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic last
);

  localparam int unsigned CntW = clog2(N);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  assign last = (cnt_q == CntW'(N - 1));

endmodule

// File: rtl/mult_ctrl.sv
// Shift-and-add multiplier sequencer driving ACC Load/Sh/Ad strobes.
// Optional Busy output is enabled by defining MULT_CTRL_BUSY_EN.
module mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned N = MULT_N
) (
  input  logic Clk,
  input  logic Rst,
  input  logic St,
  input  logic M,
  output logic Load,
  output logic Sh,
  output logic Ad,
  output logic Done
`ifdef MULT_CTRL_BUSY_EN
  ,
  output logic Busy
`endif
);

  mult_state_e state_q, state_d;
  logic        cnt_clear, cnt_inc, cnt_last;

  mult_step_cnt #(
    .N(N)
  ) u_step_cnt (
    .clk  (Clk),
    .rst  (Rst),
    .clear(cnt_clear),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    Load      = 1'b0;
    Sh        = 1'b0;
    Ad        = 1'b0;
    Done      = 1'b0;
    cnt_clear = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (St) state_d = StLoad;
      end
      StLoad: begin
        Load      = 1'b1;
        cnt_clear = 1'b1;
        state_d   = StTest;
      end
      StTest: begin
        // M is the multiplier bit now sitting in ACC bit 0.
        if (M) begin
          Ad      = 1'b1;
          state_d = StShift;
        end else begin
          Sh      = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_last) state_d = StDone;
        end
      end
      StShift: begin
        Sh      = 1'b1;
        cnt_inc = 1'b1;
        state_d = cnt_last ? StDone : StTest;
      end
      StDone: begin
        Done = 1'b1;
        if (!St) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef MULT_CTRL_BUSY_EN
  assign Busy = (state_q inside {StLoad, StTest, StShift});
`endif

endmodule

// File: tb/tb_mult_ctrl.sv
// Self-checking bench for mult_ctrl with a behavioural ACC and strobe-trace reference.
module tb_mult_ctrl;
  import mult_pkg::*;

  localparam int unsigned N = MULT_N;

  logic Clk = 1'b0;
  logic Rst, St, M, Load, Sh, Ad, Done;
`ifdef MULT_CTRL_BUSY_EN
  logic Busy;
`endif

  logic [MULT_ACC_W-1:0] acc;
  logic [N-1:0]          mplier, mcand;
  logic                  m_rand_en, m_rand;
  int                    checks   = 0;
  int                    failures = 0;

  always #5 Clk = ~Clk;

  mult_ctrl #(
    .N(N)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .St  (St),
    .M   (M),
    .Load(Load),
    .Sh  (Sh),
    .Ad  (Ad),
    .Done(Done)
`ifdef MULT_CTRL_BUSY_EN
    ,
    .Busy(Busy)
`endif
  );

  // Behavioural accumulator responding to the strobes.
  always @(posedge Clk) begin
    if (Rst) acc <= '0;
    else if (Load) acc <= {{(N + 1){1'b0}}, mplier};
    else if (Ad) acc <= {({1'b0, acc[2*N-1:N]} + {1'b0, mcand}), acc[N-1:0]};
    else if (Sh) acc <= acc >> 1;
  end

  assign M = m_rand_en ? m_rand : acc[0];

  function automatic byte strobe_code();
    int n;
    if ($isunknown({Load, Sh, Ad, Done})) return "?";
    n = int'(Load) + int'(Sh) + int'(Ad) + int'(Done);
    if (n > 1) return "X";
    if (Load) return "L";
    if (Ad) return "A";
    if (Sh) return "S";
    if (Done) return "D";
    return "-";
  endfunction

  // Expected trace: L, then per multiplier bit (LSB first) A,S or S, then D.
  task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b, input bit hold_st,
                          input string name);
    byte                   exp_q[$];
    byte                   obs;
    logic [MULT_ACC_W-1:0] exp_p;
    mplier = a;
    mcand  = b;
    exp_p  = a * b;
    exp_q.push_back("L");
    for (int i = 0; i < N; i++) begin
      if (a[i]) exp_q.push_back("A");
      exp_q.push_back("S");
    end
    exp_q.push_back("D");
    St = 1'b1;
    for (int k = 1; k <= exp_q.size(); k++) begin
      @(posedge Clk); #1;
      if (!hold_st) St = 1'b0;
      obs = strobe_code();
      checks++;
      if (obs !== exp_q[k-1]) begin
        failures++;
        $display("FAIL %s cycle %0d: strobe %c, required %c", name, k, obs, exp_q[k-1]);
      end
`ifdef MULT_CTRL_BUSY_EN
      checks++;
      if (Busy !== (k < exp_q.size())) begin
        failures++;
        $display("FAIL %s_busy cycle %0d: Busy %b, required %b", name, k, Busy,
                 k < exp_q.size());
      end
`endif
    end
    checks++;
    if (acc !== exp_p) begin
      failures++;
      $display("FAIL %s product: acc %0d, required %0d", name, acc, exp_p);
    end
    if (!hold_st) begin
      @(posedge Clk); #1;
      obs = strobe_code();
      checks++;
      if (obs !== "-") begin
        failures++;
        $display("FAIL %s return_idle: strobe %c, required -", name, obs);
      end
    end
  endtask

  task automatic test_reset();
    byte obs;
    Rst = 1'b1;
    St  = 1'b1;
    repeat (2) begin
      @(posedge Clk); #1;
      obs = strobe_code();
      checks++;
      if (obs !== "-") begin
        failures++;
        $display("FAIL reset_hold: strobe %c, required -", obs);
      end
    end
    Rst = 1'b0;
    St  = 1'b0;
    @(posedge Clk); #1;
    obs = strobe_code();
    checks++;
    if (obs !== "-") begin
      failures++;
      $display("FAIL reset_release: strobe %c, required -", obs);
    end
  endtask

  task automatic test_fixed();
    run_mult(4'b0101, 4'b0111, 1'b0, "mul_0101x0111");
    run_mult(4'b0000, 4'($urandom), 1'b0, "mul_0000");
    run_mult(4'b1111, 4'($urandom), 1'b0, "mul_1111");
    run_mult(4'b1111, 4'b1111, 1'b0, "mul_max");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_mult(4'($urandom), 4'($urandom), 1'b0, "mul_rand");
    end
  endtask

  task automatic test_handshake();
    byte obs;
    bit  seen;
    run_mult(4'($urandom), 4'($urandom), 1'b1, "hold");
    repeat (4) begin
      @(posedge Clk); #1;
      obs = strobe_code();
      checks++;
      if (obs !== "D") begin
        failures++;
        $display("FAIL hold_done: strobe %c, required D", obs);
      end
    end
    St = 1'b0;
    @(posedge Clk); #1;
    obs = strobe_code();
    checks++;
    if (obs !== "-") begin
      failures++;
      $display("FAIL hold_release: strobe %c, required -", obs);
    end
    St = 1'b1;
    @(posedge Clk); #1;
    St  = 1'b0;
    obs = strobe_code();
    checks++;
    if (obs !== "L") begin
      failures++;
      $display("FAIL hold_restart: strobe %c, required L", obs);
    end
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge Clk); #1;
      seen = (Done === 1'b1);
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL hold_restart_done: Done 0 within 20 cycles, required 1");
    end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    byte obs;
    mplier = 4'b0101;
    mcand  = 4'b0111;
    St     = 1'b1;
    @(posedge Clk); #1;
    St = 1'b0;
    repeat (2) begin
      @(posedge Clk); #1;
    end
    Rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge Clk); #1;
      Rst = 1'b0;
      obs = strobe_code();
      checks++;
      if (obs !== "-") begin
        failures++;
        $display("FAIL reset_mid cycle %0d: strobe %c, required -", k, obs);
      end
    end
    run_mult(4'b0101, 4'b0111, 1'b0, "reset_mid_restart");
  endtask

  task automatic test_exclusive();
    m_rand_en = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      St     = ($urandom_range(0, 3) == 0);
      m_rand = 1'($urandom);
      @(posedge Clk); #1;
      checks++;
      if ((Ad && Sh) || (Load && Ad) || (Load && Sh)) begin
        failures++;
        $display("FAIL exclusive cycle %0d: Load %b Sh %b Ad %b, required at most one", i,
                 Load, Sh, Ad);
      end
`ifdef MULT_CTRL_BUSY_EN
      // Every busy state asserts exactly one of Load/Sh/Ad.
      checks++;
      if (Busy !== (Load | Sh | Ad)) begin
        failures++;
        $display("FAIL exclusive_busy cycle %0d: Busy %b, required %b", i, Busy,
                 Load | Sh | Ad);
      end
`endif
    end
    m_rand_en = 1'b0;
    St        = 1'b0;
    Rst       = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
  endtask

  initial begin
    Rst       = 1'b1;
    St        = 1'b0;
    m_rand_en = 1'b0;
    m_rand    = 1'b0;
    mplier    = '0;
    mcand     = '0;
    @(posedge Clk); #1;
    test_reset();
    test_fixed();
    test_random();
    test_handshake();
    test_reset_mid();
    test_exclusive();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
